rc4_ksa_engine: RTL
===================

RC4_KSA_ENGINE -- requirements
Module: rc4_ksa_engine

Interface
REQ-001 Parameter KEY_BYTES, default 3, number of key bytes cycled by the schedule (>=1).
REQ-002 Parameter ADDR_W, default 8, S-memory address width; DEPTH = 2**ADDR_W; S data width and key byte width both equal ADDR_W.
REQ-003 Port clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port reset  input  1  reset, synchronous, active-high.
REQ-005 Port start  input  1  one-cycle request to run the key schedule.
REQ-006 Port key  input  KEY_BYTES*ADDR_W  secret key; byte k = key[ADDR_W*(KEY_BYTES-1-k) +: ADDR_W] (byte 0 most significant).
REQ-007 Port mem_rdata  input  ADDR_W  S-memory read data, valid one cycle after address.
REQ-008 Port mem_addr  output  ADDR_W  S-memory address, registered.
REQ-009 Port mem_wdata  output  ADDR_W  S-memory write data, registered.
REQ-010 Port mem_wr_en  output  1  S-memory write strobe, registered.
REQ-011 Port busy  output  1  high from start acceptance until done.
REQ-012 Port done  output  1  one-cycle completion pulse.

Function
REQ-013 States: IDLE, FILL, RD_SI, LAT_SI, RD_SJ, LAT_SJ, WR_I, WR_J, NEXT, DONE.
REQ-014 IDLE: start=1 latches key, clears i, j, k to 0, asserts busy, enters FILL (macro on) or RD_SI (macro off).
REQ-015 start while busy is ignored; key changes while busy have no effect.
REQ-016 RD_SI: mem_addr=i, mem_wr_en=0.
REQ-017 LAT_SI: si<=mem_rdata; j<=(j + mem_rdata + key byte k) mod DEPTH.
REQ-018 RD_SJ: mem_addr=j (updated), mem_wr_en=0; LAT_SJ: sj<=mem_rdata.
REQ-019 WR_I: mem_addr=i, mem_wdata=sj, mem_wr_en=1; WR_J: mem_addr=j, mem_wdata=si, mem_wr_en=1.
REQ-020 NEXT: mem_wr_en=0; i<=i+1; k<=k+1, wrapping to 0 after KEY_BYTES-1 (counter, no modulo operator); if i was DEPTH-1 go DONE else RD_SI.
REQ-021 Each shuffle iteration takes exactly 7 cycles; i==j case performs both writes with identical data (S unchanged).
REQ-022 DONE: done=1 for one cycle, busy=0, then IDLE; start in DONE cycle ignored.
REQ-023 mem_wr_en is 1 only in FILL, WR_I, WR_J; all j/i arithmetic is mod DEPTH (natural wrap).

Reset
REQ-024 reset=1 forces IDLE; mem_addr=0, mem_wdata=0, mem_wr_en=0, busy=0, done=0, i=j=k=0, si=sj=0.
REQ-025 reset mid-operation aborts on that edge with no further writes; S contents left as-is; next start re-runs fully.
REQ-026 reset has priority over start in the same cycle.

Configuration
REQ-027 Macro RC4_KSA_INIT_FILL_EN defined: FILL state writes mem_addr=i, mem_wdata=i, mem_wr_en=1 for i=0..DEPTH-1, one per cycle, then i=0 and RD_SI; start-to-DONE = 8*DEPTH cycles.
REQ-028 Macro undefined: FILL state absent, S assumed pre-initialised externally; start-to-DONE = 7*DEPTH cycles.

Structure
REQ-029 Package rc4_pkg holds the state enum typedef and default localparams (KEY_BYTES=3, ADDR_W=8).
REQ-030 Sub-module rc4_key_sel holds the key latch, rotating index k and byte mux, with clear and advance inputs.

Verification
REQ-031 ADDR_W=2, KEY_BYTES=1, key=0, macro on, start -> final S=[0,2,3,1], done after 32 cycles.
REQ-032 ADDR_W=2, KEY_BYTES=1, key=1, macro on -> final S=[0,2,3,1]; i=0 iteration writes S[0]=1, S[1]=0.
REQ-033 ADDR_W=8, KEY_BYTES=3, key=24'h000249, macro off, S pre-filled identity -> S matches software RC4 KSA model; done exactly 1792 cycles after start edge.
REQ-034 Start pulse during busy -> ignored, completion time and S result unchanged.
REQ-035 reset asserted in WR_I of iteration 5 -> next edge mem_wr_en=0, busy=0, state IDLE; fresh start completes correctly.
REQ-036 i==j iteration (ADDR_W=2, key=0, i=0) -> two writes of 0 to address 0, S unchanged.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and defaults for the RC4 key-scheduling engine.
// Optional macro RC4_KSA_INIT_FILL_EN enables the built-in identity fill of S.
package rc4_pkg;

    localparam int KEY_BYTES_DEF = 3;
    localparam int ADDR_W_DEF    = 8;

    typedef enum logic [3:0] {
        IDLE,
        FILL,
        RD_SI,
        LAT_SI,
        RD_SJ,
        LAT_SJ,
        WR_I,
        WR_J,
        NEXT,
        DONE
    } ksa_state_e;

endpackage

// File: rtl/rc4_key_sel.sv
// Key latch plus rotating byte index k; byte 0 is the most significant key byte.
module rc4_key_sel
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        advance,
    input  logic [KEY_BYTES*ADDR_W-1:0] key,
    output logic [ADDR_W-1:0]           key_byte
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    logic [KEY_BYTES*ADDR_W-1:0] key_q, key_d;
    logic [KW-1:0]               k_q, k_d;

    always_comb begin
        key_d = key_q;
        k_d   = k_q;
        if (clear) begin
            key_d = key;
            k_d   = '0;
        end else if (advance) begin
            k_d = (k_q == KW'(KEY_BYTES - 1)) ? '0 : k_q + 1'b1;
        end
    end

    always_comb begin
        key_byte = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (k_q == KW'(b)) begin
                key_byte = key_q[ADDR_W*(KEY_BYTES-1-b) +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q <= '0;
            k_q   <= '0;
        end else begin
            key_q <= key_d;
            k_q   <= k_d;
        end
    end

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine driving an external synchronous S-memory.
// Define RC4_KSA_INIT_FILL_EN to fill S with the identity before shuffling.
module rc4_ksa_engine
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [KEY_BYTES*ADDR_W-1:0] key,
    input  logic [ADDR_W-1:0]           mem_rdata,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [ADDR_W-1:0]           mem_wdata,
    output logic                        mem_wr_en,
    output logic                        busy,
    output logic                        done
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    ksa_state_e        state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [ADDR_W-1:0] j_q, j_d;
    logic [ADDR_W-1:0] si_q, si_d;
    logic [ADDR_W-1:0] sj_q, sj_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wdata_q, wdata_d;
    logic              wr_en_q, wr_en_d;
    logic              key_clear;
    logic              key_adv;
    logic [ADDR_W-1:0] key_byte;

    rc4_key_sel #(
        .KEY_BYTES (KEY_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_key_sel (
        .clk      (clk),
        .reset    (reset),
        .clear    (key_clear),
        .advance  (key_adv),
        .key      (key),
        .key_byte (key_byte)
    );

    // Memory-port registers are loaded for the state being entered.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        si_d      = si_q;
        sj_d      = sj_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_en_d   = 1'b0;
        key_clear = 1'b0;
        key_adv   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    key_clear = 1'b1;
                    i_d       = '0;
                    j_d       = '0;
                    addr_d    = '0;
`ifdef RC4_KSA_INIT_FILL_EN
                    state_d   = FILL;
                    wdata_d   = '0;
                    wr_en_d   = 1'b1;
`else
                    state_d   = RD_SI;
`endif
                end
            end
`ifdef RC4_KSA_INIT_FILL_EN
            FILL: begin
                if (i_q == LAST) begin
                    i_d     = '0;
                    addr_d  = '0;
                    state_d = RD_SI;
                end else begin
                    i_d     = i_q + 1'b1;
                    addr_d  = i_q + 1'b1;
                    wdata_d = i_q + 1'b1;
                    wr_en_d = 1'b1;
                end
            end
`endif
            RD_SI: state_d = LAT_SI;
            LAT_SI: begin
                si_d    = mem_rdata;
                j_d     = j_q + mem_rdata + key_byte;
                addr_d  = j_d;
                state_d = RD_SJ;
            end
            RD_SJ: state_d = LAT_SJ;
            LAT_SJ: begin
                sj_d    = mem_rdata;
                addr_d  = i_q;
                wdata_d = mem_rdata;
                wr_en_d = 1'b1;
                state_d = WR_I;
            end
            WR_I: begin
                addr_d  = j_q;
                wdata_d = si_q;
                wr_en_d = 1'b1;
                state_d = WR_J;
            end
            WR_J: state_d = NEXT;
            NEXT: begin
                i_d     = i_q + 1'b1;
                addr_d  = i_q + 1'b1;
                key_adv = 1'b1;
                state_d = (i_q == LAST) ? DONE : RD_SI;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_en_q <= wr_en_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wr_en = wr_en_q;
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);

endmodule
